br_cmp: RTL and testbench



---
 rtl/br_cmp.sv | 68 ++++++
 tb/tb_br_cmp.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/br_cmp.sv
// br_cmp: RV32I branch comparator (signed/unsigned less-than, equal) with funct3 branch decode.
// Define BRCMP_PIPE_EN to register brlt/breq/br_taken into the *_q outputs; otherwise they are wires.
module br_cmp (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        brun,
  input  logic [2:0]  funct3,
  input  logic        br_en,
  output logic        brlt,
  output logic        breq,
  output logic        br_taken,
  output logic        br_illegal,
  output logic        brlt_q,
  output logic        breq_q,
  output logic        br_taken_q
);

  logic        xa;
  logic        xb;
  logic [32:0] diff;

  // One 33-bit subtract covers both modes: zero-extend for unsigned, sign-extend for signed.
  assign xa   = brun ? 1'b0 : a[31];
  assign xb   = brun ? 1'b0 : b[31];
  assign diff = {xa, a} - {xb, b};
  assign brlt = diff[32];
  assign breq = (a == b);

  assign br_illegal = br_en & (funct3[2:1] == 2'b01);

  always_comb begin
    br_taken = 1'b0;
    if (br_en) begin
      case (funct3)
        3'b000:         br_taken = breq;
        3'b001:         br_taken = !breq;
        3'b100, 3'b110: br_taken = brlt;
        3'b101, 3'b111: br_taken = !brlt;
        default:        br_taken = 1'b0;
      endcase
    end
  end

`ifdef BRCMP_PIPE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brlt_q     <= 1'b0;
      breq_q     <= 1'b0;
      br_taken_q <= 1'b0;
    end else begin
      brlt_q     <= brlt;
      breq_q     <= breq;
      br_taken_q <= br_taken;
    end
  end
`else
  // Clock and reset have no load in the unpipelined build.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  assign brlt_q     = brlt;
  assign breq_q     = breq;
  assign br_taken_q = br_taken;
`endif

endmodule

// File: tb/tb_br_cmp.sv
// Self-checking bench for br_cmp: random compare regression against a behavioural model,
// directed boundary/decode cases, and pipeline/reset behaviour for either build.
module tb_br_cmp;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        brun;
  logic [2:0]  funct3;
  logic        br_en;
  logic        brlt;
  logic        breq;
  logic        br_taken;
  logic        br_illegal;
  logic        brlt_q;
  logic        breq_q;
  logic        br_taken_q;

  int n_chk;
  int n_fail;

  br_cmp dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .brun       (brun),
    .funct3     (funct3),
    .br_en      (br_en),
    .brlt       (brlt),
    .breq       (breq),
    .br_taken   (br_taken),
    .br_illegal (br_illegal),
    .brlt_q     (brlt_q),
    .breq_q     (breq_q),
    .br_taken_q (br_taken_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: branch semantics straight from the ISA rules.
  function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input logic mbrun,
                                input logic [2:0] f3, input logic en,
                                output logic lt, output logic eq, output logic tk, output logic ill);
    eq  = (ma == mb);
    lt  = mbrun ? (ma < mb) : ($signed(ma) < $signed(mb));
    ill = en && (f3 == 3'b010 || f3 == 3'b011);
    tk  = 1'b0;
    if (en) begin
      case (f3)
        3'b000:         tk = eq;
        3'b001:         tk = !eq;
        3'b100, 3'b110: tk = lt;
        3'b101, 3'b111: tk = !lt;
        default:        tk = 1'b0;
      endcase
    end
  endfunction

  task automatic apply(input logic [31:0] va, input logic [31:0] vb, input logic vbrun,
                       input logic [2:0] vf3, input logic ven);
    a = va; b = vb; brun = vbrun; funct3 = vf3; br_en = ven;
    #2;
  endtask

  task automatic chk_model(input string tag);
    logic lt, eq, tk, ill;
    model(a, b, brun, funct3, br_en, lt, eq, tk, ill);
    chk({tag, ".brlt"}, brlt, lt);
    chk({tag, ".breq"}, breq, eq);
    chk({tag, ".taken"}, br_taken, tk);
    chk({tag, ".illegal"}, br_illegal, ill);
  endtask

  initial begin
    logic lt, eq, tk, ill;
    int f0;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    a = '0; b = '0; brun = 1'b0; funct3 = 3'b000; br_en = 1'b0;
    #3;
    chk("reset.brlt_q", brlt_q, 1'b0);
`ifdef BRCMP_PIPE_EN
    chk("reset.breq_q", breq_q, 1'b0);
    chk("reset.taken_q", br_taken_q, 1'b0);
`else
    chk("reset.breq_q", breq_q, 1'b1);
    chk("reset.taken_q", br_taken_q, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Random regression; every fourth iteration forces a == b to exercise equality.
    for (int i = 0; i < 100; i++) begin
      logic [31:0] ra, rb;
      f0 = n_fail;
      @(negedge clk);
      ra = $urandom;
      rb = (i % 4 == 3) ? ra : $urandom;
      if (i % 8 == 5) rb = ra ^ (32'h1 << $urandom_range(31, 0));
      apply(ra, rb, 1'($urandom), 3'($urandom), 1'($urandom));
      #48;
      model(a, b, brun, funct3, br_en, lt, eq, tk, ill);
      chk("rand.brlt", brlt, lt);
      chk("rand.breq", breq, eq);
      chk("rand.taken", br_taken, tk);
      chk("rand.illegal", br_illegal, ill);
      chk("rand.brlt_q", brlt_q, lt);
      chk("rand.breq_q", breq_q, eq);
      chk("rand.taken_q", br_taken_q, tk);
      if (n_fail != f0) break;
    end

    // Sign boundary
    apply(32'h8000_0000, 32'h0000_0001, 1'b0, 3'b000, 1'b0);
    chk("sign.s.brlt", brlt, 1'b1);
    chk("sign.s.breq", breq, 1'b0);
    chk_model("sign.s");
    apply(32'h8000_0000, 32'h0000_0001, 1'b1, 3'b000, 1'b0);
    chk("sign.u.brlt", brlt, 1'b0);
    chk("sign.u.breq", breq, 1'b0);
    chk_model("sign.u");

    // Equality of all-ones
    for (int m = 0; m < 2; m++) begin
      apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'(m), 3'b000, 1'b1);
      chk("eq.breq", breq, 1'b1);
      chk("eq.brlt", brlt, 1'b0);
      chk("eq.beq_taken", br_taken, 1'b1);
      apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'(m), 3'b001, 1'b1);
      chk("eq.bne_taken", br_taken, 1'b0);
    end

    // Branch decode: -2 vs 2
    apply(32'hFFFF_FFFE, 32'h0000_0002, 1'b0, 3'b100, 1'b1);
    chk("dec.blt", br_taken, 1'b1);
    apply(32'hFFFF_FFFE, 32'h0000_0002, 1'b1, 3'b111, 1'b1);
    chk("dec.bgeu", br_taken, 1'b1);
    apply(32'hFFFF_FFFE, 32'h0000_0002, 1'b0, 3'b101, 1'b1);
    chk("dec.bge", br_taken, 1'b0);
    apply(32'hFFFF_FFFE, 32'h0000_0002, 1'b1, 3'b110, 1'b1);
    chk("dec.bltu", br_taken, 1'b0);
    apply(32'hFFFF_FFFE, 32'h0000_0002, 1'b1, 3'b010, 1'b1);
    chk("dec.f010.taken", br_taken, 1'b0);
    chk("dec.f010.illegal", br_illegal, 1'b1);
    apply(32'hFFFF_FFFE, 32'h0000_0002, 1'b1, 3'b011, 1'b1);
    chk("dec.f011.illegal", br_illegal, 1'b1);
    apply(32'hFFFF_FFFE, 32'h0000_0002, 1'b0, 3'b100, 1'b0);
    chk("dec.noen.taken", br_taken, 1'b0);
    chk("dec.noen.illegal", br_illegal, 1'b0);

    // Pipeline and reset
    @(negedge clk);
    apply(32'd9, 32'd9, 1'b0, 3'b000, 1'b1);
    @(posedge clk); #1;
    chk("pipe.pre.breq_q", breq_q, 1'b1);
    chk("pipe.pre.taken_q", br_taken_q, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("pipe.rst.breq", breq, 1'b1);
`ifdef BRCMP_PIPE_EN
    chk("pipe.rst.brlt_q", brlt_q, 1'b0);
    chk("pipe.rst.breq_q", breq_q, 1'b0);
    chk("pipe.rst.taken_q", br_taken_q, 1'b0);
    @(posedge clk); #1;
    chk("pipe.rst_hold.breq_q", breq_q, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    apply(32'd5, 32'd5, 1'b0, 3'b000, 1'b1);
    chk("pipe.before_edge.breq_q", breq_q, 1'b0);
    @(posedge clk); #1;
    chk("pipe.lat1.breq_q", breq_q, 1'b1);
    chk("pipe.lat1.taken_q", br_taken_q, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("pipe.pulse.breq_q", breq_q, 1'b0);
    rst = 1'b0;
    #1;
    chk("pipe.pulse_hold.breq_q", breq_q, 1'b0);
    @(posedge clk); #1;
    chk("pipe.recap.breq_q", breq_q, 1'b1);
    @(negedge clk);
    apply(32'd5, 32'd6, 1'b0, 3'b000, 1'b1);
    chk("pipe.stale.breq_q", breq_q, 1'b1);
    @(posedge clk); #1;
    chk("pipe.new.breq_q", breq_q, 1'b0);
    chk("pipe.new.brlt_q", brlt_q, 1'b1);
`else
    chk("pipe.rst.brlt_q", brlt_q, 1'b0);
    chk("pipe.rst.breq_q", breq_q, 1'b1);
    chk("pipe.rst.taken_q", br_taken_q, 1'b1);
    apply(32'd5, 32'd6, 1'b0, 3'b000, 1'b1);
    chk("pipe.wire.breq_q", breq_q, 1'b0);
    chk("pipe.wire.brlt_q", brlt_q, 1'b1);
    chk("pipe.wire.taken_q", br_taken_q, 1'b0);
    rst = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
